// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants for the 7-segment scan controller
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SEG_W      = 7;

  localparam logic [NUM_DIGITS-1:0] DS_EN_OFF = 4'b1111;

  // Per-slot scan state
  localparam logic [0:0] ST_BLANK  = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Hex digit to segment mask, bit order {A,B,C,D,E,F,G}
  localparam logic [SEG_W-1:0] SEG_TABLE [0:15] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// rtl/display_scan_ctrl_scan_timer.sv - slot counter, digit index and frame strobes
module scan_timer
  import display_pkg::*;
#(
  parameter int PRESCALE_W   = 12,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [1:0] digit,
  output logic [0:0] state,
  output logic       frame_first,
  output logic       frame_wrap
);

  localparam logic [PRESCALE_W-1:0] BLANK_LIM = PRESCALE_W'(BLANK_CYCLES);

  logic [PRESCALE_W-1:0] slot_cnt;
  logic                  slot_wrap;

  assign slot_wrap = &slot_cnt;

  // Free-running slot counter; each wrap moves the scan to the next digit
  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_cnt <= '0;
      digit    <= 2'd0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (slot_wrap) begin
        digit <= digit + 2'd1;
      end
    end
  end

  // Leading cycles of every slot are dark so the previous digit cannot ghost
  assign state       = (slot_cnt < BLANK_LIM) ? ST_BLANK : ST_ACTIVE;
  // First cycle of digit 0, and last cycle of digit 3 (the commit point)
  assign frame_first = (slot_cnt == '0) && (digit == 2'd0);
  assign frame_wrap  = slot_wrap && (digit == 2'd3);

endmodule

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - tear-free 4-digit 7-segment scan controller (option: DISPLAY_SCAN_DIM_EN)
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int PRESCALE_W   = 12,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [15:0]           in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_DIGITS-1:0] digit_mask,
`ifdef DISPLAY_SCAN_DIM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [NUM_DIGITS-1:0] DS_EN,
  output logic [SEG_W-1:0]      DS_SEG,
  output logic                  frame_start
);

  logic [1:0]            digit;
  logic [0:0]            state;
  logic                  frame_first;
  logic                  commit;
  logic [15:0]           pending_word;
  logic                  pending_full;
  logic [15:0]           disp_word;
  logic                  xfer;
  logic                  lit;
  logic [3:0]            nibble;
  logic [NUM_DIGITS-1:0] en_next;
  logic [SEG_W-1:0]      seg_next;

  scan_timer #(
    .PRESCALE_W   (PRESCALE_W),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .CLK         (CLK),
    .RST         (RST),
    .digit       (digit),
    .state       (state),
    .frame_first (frame_first),
    .frame_wrap  (commit)
  );

  // The commit cycle frees the buffer, so a new word may enter in that same cycle
  assign in_ready = !RST && (!pending_full || commit);
  assign xfer     = in_valid && in_ready;

  // Pending buffer and display register; the displayed word only changes at a frame boundary
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending_word <= 16'h0000;
      pending_full <= 1'b0;
      disp_word    <= 16'h0000;
    end else begin
      if (commit && pending_full) begin
        disp_word    <= pending_word;
        pending_full <= 1'b0;
      end
      if (xfer) begin
        pending_word <= in_data;
        pending_full <= 1'b1;
      end
    end
  end

`ifdef DISPLAY_SCAN_DIM_EN
  logic [3:0] pwm;

  // Free-running duty counter compared against the requested brightness
  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm <= 4'd0;
    end else begin
      pwm <= pwm + 4'd1;
    end
  end

  assign lit = (pwm < brightness);
`else
  assign lit = 1'b1;
`endif

  assign nibble = disp_word[{digit, 2'b00} +: 4];

  // Select the enable/segment pattern for the current scan position
  always_comb begin
    en_next  = DS_EN_OFF;
    seg_next = '0;
    if ((state == ST_ACTIVE) && !digit_mask[digit] && lit) begin
      en_next  = ~(4'b0001 << digit);
      seg_next = SEG_TABLE[nibble];
    end
  end

  // Pin-facing outputs are registered to keep them glitch-free
  always_ff @(posedge CLK) begin
    if (RST) begin
      DS_EN       <= DS_EN_OFF;
      DS_SEG      <= '0;
      frame_start <= 1'b0;
    end else begin
      DS_EN       <= en_next;
      DS_SEG      <= seg_next;
      frame_start <= frame_first;
    end
  end

endmodule
